cpu_linux_oci_dct_packer: RTL and testbench

Parametrised debug-capture-trace (DCT) packer for the cpu_linux on-chip instrumentation. It collects narrow trace slots from the OCI trace source and packs them into wide DCT words with a valid-slot count. Packed words are buffered in a small FIFO for the trace sink. It also runs an end-of-test handshake: `test_ending` flushes any partial word, and `test_has_ended` asserts once everything has drained. It replaces the fixed 30-bit/4-bit DCT observation path with configurable slot width, slot count and buffer depth.

---
 rtl/cpu_linux_oci_dct_pkg.sv | 19 +
 rtl/cpu_linux_oci_dct_fifo.sv | 41 ++++
 rtl/cpu_linux_oci_dct_packer.sv | 133 +++++++++++++
 tb/tb_cpu_linux_oci_dct_packer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_linux_oci_dct_pkg.sv
// Shared types and constants for the cpu_linux OCI debug-capture-trace packer.
// Holds the packer state encoding, the slot-count width helper and the drop-counter width.
package cpu_linux_oci_dct_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ENDED = 2'd3
    } dct_state_e;

    localparam int DROP_CNT_W = 16;

    // Width needed to hold a valid-slot count of 0..slots.
    function automatic int dct_cnt_w(input int slots);
        return $clog2(slots + 1);
    endfunction

endpackage

// File: rtl/cpu_linux_oci_dct_fifo.sv
// Synchronous word FIFO for packed DCT entries; wrap-bit pointers give full/empty.
// Head data is combinational from the read pointer; storage itself is not reset.
module cpu_linux_oci_dct_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/cpu_linux_oci_dct_packer.sv
// Packs narrow OCI trace slots into wide DCT words, buffers them and runs the end-of-test flush.
// Define CPU_LINUX_OCI_DCT_DROP_EN to drop slots on a full FIFO instead of backpressuring.
module cpu_linux_oci_dct_packer
    import cpu_linux_oci_dct_pkg::*;
#(
    parameter int SLOT_W = 10,
    parameter int SLOTS  = 3,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = dct_cnt_w(SLOTS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tr_valid,
    input  logic [SLOT_W-1:0]       tr_data,
    output logic                    tr_ready,
    input  logic                    test_ending,
    output logic                    dct_valid,
    input  logic                    dct_ready,
    output logic [SLOTS*SLOT_W-1:0] dct_buffer,
    output logic [CNT_W-1:0]        dct_count,
    output logic                    test_has_ended,
    output logic [DROP_CNT_W-1:0]   drop_count
);

    localparam int WORD_W = SLOTS * SLOT_W;
    localparam int ENT_W  = WORD_W + CNT_W;

    dct_state_e        state;
    logic [WORD_W-1:0] part_q;
    logic [WORD_W-1:0] part_next;
    logic [CNT_W-1:0]  part_cnt;
    logic              fifo_full;
    logic              fifo_empty;
    logic              accept;
    logic              last_slot;
    logic              flush_push;
    logic              push;
    logic              pop;
    logic [ENT_W-1:0]  push_data;
    logic [ENT_W-1:0]  head;

`ifdef CPU_LINUX_OCI_DCT_DROP_EN
    assign tr_ready = (state == ST_RUN);
`else
    assign tr_ready = (state == ST_RUN) && !fifo_full;
`endif

    // In drop mode tr_ready ignores the FIFO, so acceptance still gates on space.
    assign accept     = tr_valid && tr_ready && !fifo_full;
    assign last_slot  = (part_cnt == CNT_W'(SLOTS - 1));
    assign flush_push = (state == ST_FLUSH) && (part_cnt != '0) && !fifo_full;
    assign push       = (accept && last_slot) || flush_push;
    assign pop        = dct_valid && dct_ready;

    always_comb begin
        part_next = part_q;
        part_next[int'(part_cnt) * SLOT_W +: SLOT_W] = tr_data;
    end

    assign push_data = flush_push ? {part_cnt, part_q} : {CNT_W'(SLOTS), part_next};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_RUN;
            part_q         <= '0;
            part_cnt       <= '0;
            test_has_ended <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (accept) begin
                        if (last_slot) begin
                            part_q   <= '0;
                            part_cnt <= '0;
                        end else begin
                            part_q   <= part_next;
                            part_cnt <= part_cnt + CNT_W'(1);
                        end
                    end
                    if (test_ending) state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (part_cnt == '0) begin
                        state <= ST_DRAIN;
                    end else if (!fifo_full) begin
                        part_q   <= '0;
                        part_cnt <= '0;
                        state    <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty) begin
                        state          <= ST_ENDED;
                        test_has_ended <= 1'b1;
                    end
                end
                default: state <= ST_ENDED;
            endcase
        end
    end

`ifdef CPU_LINUX_OCI_DCT_DROP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count <= '0;
        end else if (tr_valid && tr_ready && fifo_full && (drop_count != '1)) begin
            drop_count <= drop_count + 1'b1;
        end
    end
`else
    assign drop_count = '0;
`endif

    cpu_linux_oci_dct_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (push_data),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The sink sees zeros whenever no word is presented.
    assign dct_valid  = !fifo_empty;
    assign dct_buffer = dct_valid ? head[WORD_W-1:0] : '0;
    assign dct_count  = dct_valid ? head[ENT_W-1 -: CNT_W] : '0;

endmodule

// File: tb/tb_cpu_linux_oci_dct_packer.sv
// Directed bench for cpu_linux_oci_dct_packer with a word scoreboard fed by a slot-level model.
// Build with CPU_LINUX_OCI_DCT_DROP_EN defined to exercise drop mode instead of backpressure.
module tb_cpu_linux_oci_dct_packer;

    localparam int SLOT_W = 10;
    localparam int SLOTS  = 3;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 2;
    localparam int WORD_W = SLOT_W * SLOTS;

    // Handshakes: a slot moves on a rising edge where tr_valid & tr_ready, a word where dct_valid & dct_ready.
    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              tr_valid = 1'b0;
    logic [SLOT_W-1:0] tr_data = '0;
    logic              tr_ready;
    logic              test_ending = 1'b0;
    logic              dct_valid;
    logic              dct_ready = 1'b0;
    logic [WORD_W-1:0] dct_buffer;
    logic [CNT_W-1:0]  dct_count;
    logic              test_has_ended;
    logic [15:0]       drop_count;

    logic [31:0]       exp_q[$];
    logic [31:0]       mon_exp;
    logic [WORD_W-1:0] m_word = '0;
    int                m_cnt = 0;
    int                n_cmp = 0;
    int                n_err = 0;
    int                cyc = 0;
    int                c0;

    cpu_linux_oci_dct_packer #(
        .SLOT_W (SLOT_W),
        .SLOTS  (SLOTS),
        .DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .tr_valid       (tr_valid),
        .tr_data        (tr_data),
        .tr_ready       (tr_ready),
        .test_ending    (test_ending),
        .dct_valid      (dct_valid),
        .dct_ready      (dct_ready),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .test_has_ended (test_has_ended),
        .drop_count     (drop_count)
    );

    // Clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d n_err=%0d", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Slot-level model: builds expected words and pushes them to the scoreboard.
    task automatic model_accept(input logic [SLOT_W-1:0] d);
        m_word[m_cnt*SLOT_W +: SLOT_W] = d;
        m_cnt++;
        if (m_cnt == SLOTS) begin
            exp_q.push_back({2'(SLOTS), m_word});
            m_word = '0;
            m_cnt  = 0;
        end
    endtask

    task automatic model_flush();
        if (m_cnt > 0) exp_q.push_back({2'(m_cnt), m_word});
        m_word = '0;
        m_cnt  = 0;
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_word = '0;
        m_cnt  = 0;
    endtask

    // Driver tasks: all start and finish 1 time unit after a rising edge.
    task automatic send_slot(input logic [SLOT_W-1:0] d, input bit dropped);
        bit done = 1'b0;
        tr_valid = 1'b1;
        tr_data  = d;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (tr_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        tr_valid = 1'b0;
        check("send_accept", 32'(done), 32'd1);
        if (done && !dropped) model_accept(d);
    endtask

    task automatic pulse_end();
        test_ending = 1'b1;
        @(posedge clk);
        #1;
        test_ending = 1'b0;
        model_flush();
    endtask

    task automatic drain(input int budget);
        dct_ready = 1'b1;
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #2;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Scoreboard: compare each word at the negedge before its handshake edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (dct_valid && dct_ready) begin
                check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    check("sb_word", {dct_count, dct_buffer}, mon_exp);
                end
            end else if (!dct_valid) begin
                check("idle_zero", {dct_count, dct_buffer}, 32'd0);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_dct_valid", 32'(dct_valid), 32'd0);
        check("rst_dct_word", {dct_count, dct_buffer}, 32'd0);
        check("rst_ended", 32'(test_has_ended), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(tr_ready), 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back slots at full rate.
        dct_ready = 1'b1;
        c0 = cyc;
        send_slot(10'h001, 1'b0);
        send_slot(10'h002, 1'b0);
        send_slot(10'h003, 1'b0);
        check("full_rate_cycles", 32'(cyc - c0), 32'd3);
        check("word1_valid", 32'(dct_valid), 32'd1);
        check("word1_value", {dct_count, dct_buffer}, 32'hC030_0801);
        drain(20);

        // Backpressure: four words fill the FIFO.
        dct_ready = 1'b0;
        for (int i = 0; i < 12; i++) send_slot(10'($urandom_range(0, 1023)), 1'b0);
        check("bp_queued", 32'(exp_q.size()), 32'd4);
        check("bp_dct_valid", 32'(dct_valid), 32'd1);
`ifdef CPU_LINUX_OCI_DCT_DROP_EN
        for (int i = 0; i < 5; i++) send_slot(10'($urandom_range(0, 1023)), 1'b1);
        check("drop_count", 32'(drop_count), 32'd5);
        check("drop_queue_kept", 32'(exp_q.size()), 32'd4);
`else
        tr_valid = 1'b1;
        tr_data  = 10'h2AA;
        repeat (3) begin
            @(negedge clk);
            check("bp_ready_low", 32'(tr_ready), 32'd0);
        end
        tr_valid = 1'b0;
        check("drop_count_tied", 32'(drop_count), 32'd0);
        @(posedge clk);
        #1;
`endif
        drain(40);

        // Partial flush on test_ending.
        send_slot(10'h3FF, 1'b0);
        send_slot(10'h155, 1'b0);
        pulse_end();
        for (int i = 0; i < 20 && !dct_valid; i++) @(negedge clk);
        check("flush_word", {dct_count, dct_buffer}, 32'h8005_57FF);
        #2;
        check("flush_popped", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        check("ended_at_pop_edge", 32'(test_has_ended), 32'd0);
        @(posedge clk);
        #1;
        check("ended_after_pop", 32'(test_has_ended), 32'd1);
        check("ended_ready_low", 32'(tr_ready), 32'd0);

        // Empty end: test_ending at edge E, flag after E+2.
        do_reset();
        check("empty_end_ready", 32'(tr_ready), 32'd1);
        pulse_end();
        check("empty_end_e", 32'(test_has_ended), 32'd0);
        @(posedge clk);
        #1;
        check("empty_end_e1", 32'(test_has_ended), 32'd0);
        @(posedge clk);
        #1;
        check("empty_end_e2", 32'(test_has_ended), 32'd1);
        check("empty_end_ready_low", 32'(tr_ready), 32'd0);
        check("empty_end_no_word", 32'(dct_valid), 32'd0);

        // Reset while draining with two words queued.
        do_reset();
        dct_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_slot(10'($urandom_range(0, 1023)), 1'b0);
        pulse_end();
        repeat (2) @(posedge clk);
        #1;
        check("drain_queued", 32'(exp_q.size()), 32'd2);
        check("drain_valid", 32'(dct_valid), 32'd1);
        check("drain_not_ended", 32'(test_has_ended), 32'd0);
        reset = 1'b1;
        model_clear();
        #1;
        check("midrst_valid", 32'(dct_valid), 32'd0);
        check("midrst_ended", 32'(test_has_ended), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_ready", 32'(tr_ready), 32'd1);
        @(posedge clk);
        #1;
        dct_ready = 1'b1;
        send_slot(10'h00A, 1'b0);
        send_slot(10'h00B, 1'b0);
        send_slot(10'h00C, 1'b0);
        check("midrst_word", {dct_count, dct_buffer}, 32'hC0C0_2C0A);
        drain(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
